// File: rtl/alu_pkg.sv
// Shared control codes and FSM state type for the ALU execution unit.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_XOR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_ADDU  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SUBU  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_MULT  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_MULTU = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_LUI   = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_BRK   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier on operand magnitudes; one multiplier bit per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic               step_done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic               run_q, run_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Signed ops work on magnitudes; the caller applies the product sign.
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  assign step_done = run_q && (count_q == CW'(WIDTH - 1));
  assign product   = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    run_d    = run_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      count_d  = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (step_done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle logic/arith/compare/LUI ops, iterative MULT/MULTU
// into HI/LO, and a sticky BREAK flag.
module alu_exec #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CTRL_W-1:0] control,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              ovf,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              busy,
  output logic              done,
  output logic              brk
);

  import alu_pkg::*;

  localparam int HALF = WIDTH / 2;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, brk_q, brk_d;
  logic               done_q, done_d, sign_q, sign_d;
  logic               mul_load, step_done, is_mul, in_fin;
  logic [2*WIDTH-1:0] mul_prod, prod_fin;
  logic [WIDTH-1:0]   sum, diff, op_res;
  logic               op_ovf;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .a         (a),
    .b         (b),
    .signed_op (control == ALU_MULT),
    .step_done (step_done),
    .product   (mul_prod)
  );

  assign sum      = a + b;
  assign diff     = a - b;
  assign is_mul   = (control == ALU_MULT) || (control == ALU_MULTU);
  assign in_fin   = (state_q == ST_FIN);
  assign prod_fin = sign_q ? -mul_prod : mul_prod;

  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (control)
      ALU_AND:  op_res = a & b;
      ALU_OR:   op_res = a | b;
      ALU_XOR:  op_res = a ^ b;
      ALU_ADDU: op_res = sum;
      ALU_SUBU: op_res = diff;
      ALU_ADD: begin
        op_res = sum;
        op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        op_res = diff;
        op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_LUI:  op_res = b << HALF;
      default:  op_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    brk_d    = brk_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_d   = sign_q;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            mul_load = 1'b1;
            sign_d   = (control == ALU_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
            state_d  = ST_MUL;
          end else begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            ovf_d    = op_ovf;
            done_d   = 1'b1;
            if (control == ALU_BRK) begin
              brk_d = 1'b1;
            end
          end
        end
      end
      ST_MUL: begin
        if (step_done) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        hi_d    = prod_fin[2*WIDTH-1:WIDTH];
        lo_d    = prod_fin[WIDTH-1:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      brk_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      brk_q    <= brk_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_q   <= sign_d;
    end
  end

  // FIN presents the final product and done in the same cycle; hi_q/lo_q latch it on exit.
  assign done   = done_q | in_fin;
  assign hi     = in_fin ? prod_fin[2*WIDTH-1:WIDTH] : hi_q;
  assign lo     = in_fin ? prod_fin[WIDTH-1:0] : lo_q;
  assign busy   = (state_q != ST_IDLE);
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign brk    = brk_q;

endmodule
